// File: rtl/instruc_fetch_queue.sv
// Instruction fetch front end: word-aligned imem requests, credit-limited in-order buffer, redirect flush.
// Head entry appears the cycle after its response; requests stop when buffered + in-flight reaches DEPTH.
module instruc_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruc_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [DEPTH];

  logic          rvalid_ok;
  logic          grant;
  logic          push;
  logic          pop;
  logic [CW-1:0] stale;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_pc_al;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rvalid_ok      = imem_rvalid_i & (outst_q != '0);
  assign redirect_pc_al = {redirect_pc_i[31:2], 2'b00};
  assign occupancy      = {1'b0, count_q} + {1'b0, outst_q};
  assign stale          = outst_q - CW'(rvalid_ok);

  assign imem_req_o  = (state_q != BOOT) & ~redirect_i & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o & imem_gnt_i;

  assign valid_o   = (count_q != '0);
  assign instruc_o = valid_o ? mem_q[rd_ptr_q].instr : NOP;
  assign pc_o      = valid_o ? mem_q[rd_ptr_q].pc : 32'h0;

  assign push = rvalid_ok & ~redirect_i & (discard_q == '0);
  assign pop  = valid_o & ready_i & ~redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    outst_d    = outst_q + CW'(grant) - CW'(rvalid_ok);

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      discard_d  = stale;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rvalid_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    case (state_q)
      BOOT:  state_d = RUN;
      RUN:   if (redirect_i && (stale != '0)) state_d = DRAIN;
      DRAIN: begin
        if (redirect_i)                                state_d = (stale != '0) ? DRAIN : RUN;
        else if (rvalid_ok && (discard_q == CW'(1)))   state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_rdata_i};
  end

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (outst_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_instruc_fetch_queue.sv
// Randomized and directed bench for instruc_fetch_queue against a queue-based reference model.
module tb_instruc_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instruc_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  always #5 clk = ~clk;

  instruc_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instruc_o(instruc_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  typedef struct { logic [31:0] addr; int due; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  infl_t       inflight[$];
  ent_t        fq[$];
  logic [31:0] m_fetch_pc, m_resp_pc;
  int          m_discard;
  bit          booted;
  int          cyc, lat, stall_pct;
  int          n_tests, n_fail;
  bit          dut_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit rv_ready();
    return (inflight.size() > 0) && (inflight[0].due <= cyc);
  endfunction

  task automatic model_reset();
    inflight.delete();
    fq.delete();
    m_fetch_pc = RESET_PC;
    m_resp_pc  = RESET_PC;
    m_discard  = 0;
    booted     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req_o}, 32'h0);
    chk({tag, "_addr"},  imem_addr_o, RESET_PC);
    chk({tag, "_valid"}, {31'b0, valid_o}, 32'h0);
    chk({tag, "_instr"}, instruc_o, NOP);
    chk({tag, "_pc"},    pc_o, 32'h0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit gnt);
    bit          rv, exp_req, exp_vld, grant, pop;
    int          n_infl;
    logic [31:0] data;
    ent_t        e;
    infl_t       f;
    rv = rv_ready() && ($urandom_range(99) >= stall_pct);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? (inflight[0].addr | 32'h1) : $urandom;
    #1;
    exp_req = booted && !redir && ((fq.size() + inflight.size()) < DEPTH);
    exp_vld = fq.size() > 0;
    chk("req",   {31'b0, imem_req_o}, {31'b0, exp_req});
    chk("addr",  imem_addr_o, m_fetch_pc);
    chk("valid", {31'b0, valid_o}, {31'b0, exp_vld});
    chk("pc",    pc_o, exp_vld ? fq[0].pc : 32'h0);
    chk("instr", instruc_o, exp_vld ? fq[0].ins : NOP);
    dut_grant = imem_req_o && gnt;

    n_infl = inflight.size();
    grant  = exp_req && gnt;
    data   = 32'h0;
    if (rv) begin
      f    = inflight.pop_front();
      data = f.addr | 32'h1;
    end
    pop = exp_vld && rdy && !redir;
    if (pop) void'(fq.pop_front());
    if (redir) begin
      fq.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
      m_resp_pc  = {rpc[31:2], 2'b00};
      m_discard  = n_infl - int'(rv);
    end else if (rv) begin
      if (m_discard > 0) m_discard--;
      else begin
        e.pc  = m_resp_pc;
        e.ins = data;
        fq.push_back(e);
        m_resp_pc += 32'd4;
      end
    end
    if (grant) begin
      f.addr = m_fetch_pc;
      f.due  = cyc + lat;
      inflight.push_back(f);
      m_fetch_pc += 32'd4;
    end
    booted = 1'b1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    redirect_i = 1'b0; redirect_pc_i = 32'h0; ready_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
  endtask

  initial begin
    int grants, exp_grants, budget;
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1; stall_pct = 0;
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // 1-cycle memory, full streaming; first valid appears 3 steps after release.
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1);

    // Decoder stall: only the remaining credits may be granted.
    exp_grants = DEPTH - (fq.size() + inflight.size());
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1);
      if (dut_grant) grants++;
    end
    chk("stall_grants", grants, exp_grants);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);

    // Grant withheld for three cycles: address must hold.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1);

    // 3-cycle memory with three in flight, then redirect to an unaligned target.
    lat = 3;
    budget = 0;
    while (inflight.size() != 3 && budget < 40) begin
      step(0, 0, 1, 1);
      budget++;
    end
    chk("three_inflight", inflight.size(), 3);
    step(1, 32'h0000_1003, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);

    // Redirect coinciding with a response and a pop.
    budget = 0;
    while (!(rv_ready() && fq.size() > 0) && budget < 40) begin
      step(0, 0, 1, 1);
      budget++;
    end
    chk("redir_rv_pop_setup", {31'b0, rv_ready() && fq.size() > 0}, 32'h1);
    step(1, 32'h0000_2000, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);

    // Random traffic including wraparound redirect targets.
    stall_pct = 30;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      lat = $urandom_range(4, 1);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step($urandom_range(99) < 5, rpc, $urandom_range(99) < 70, $urandom_range(99) < 70);
    end

    // Asynchronous reset with two in flight and the buffer half full.
    stall_pct = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
    step(1, 32'h0000_3000, 0, 1);
    lat = 3;
    budget = 0;
    while (!(inflight.size() == 2 && fq.size() == 2) && budget < 40) begin
      step(0, 0, 0, 1);
      budget++;
    end
    chk("midrst_setup", {31'b0, inflight.size() == 2 && fq.size() == 2}, 32'h1);
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    lat = 1;
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
